// File: rtl/gnn_pkg.sv
// gnn_pkg: shared constants, FSM state type and slot indexing for the GNN result collector
package gnn_pkg;
  localparam int NUM_NODES = 4;
  localparam int NUM_OUT = 2;
  localparam int NUM_SLOTS = NUM_NODES * NUM_OUT;
  localparam int IN_W_DEF = 21;
  localparam int OUT_W_DEF = 16;
  typedef enum logic [1:0] {ARM, COLLECT, SEND} state_t;
  function automatic logic [2:0] slot(input logic [1:0] node, input logic o);
    return {node, o};
  endfunction
endpackage

// File: rtl/gnn_sat_argmax.sv
// gnn_sat_argmax: picks the larger of two signed scores (tie -> a) and saturates it to OUT_W
//   a, b  : signed IN_W candidate scores (out0, out1)
//   cls   : 1 when b strictly exceeds a
//   score : winning score clipped to the signed OUT_W range
module gnn_sat_argmax import gnn_pkg::*; #(
  parameter int IN_W = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  output logic                    cls,
  output logic signed [OUT_W-1:0] score
);
  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  logic signed [IN_W-1:0] w;
  assign cls = b > a;
  assign w = cls ? b : a;
  assign score = w > MAX_V ? MAX_V[OUT_W-1:0] : w < MIN_V ? MIN_V[OUT_W-1:0] : w[OUT_W-1:0];
endmodule

// File: rtl/gnn_result_collector.sv
// gnn_result_collector: gathers 8 per-node results, then streams per-node argmax/score words
//   res_data/res_ready : packed result slots (slot = 2*node + out) with level ready flags
//   m_valid/m_ready    : word handshake; m_node, m_class, m_score form the word
//   frame_done         : pulse after node 3 is accepted; err_abort: pulse on mid-frame ready loss
//   frame_cnt          : wrapping count of completed frames
module gnn_result_collector import gnn_pkg::*; #(
  parameter int IN_W = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int FCNT_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SLOTS*IN_W-1:0]   res_data,
  input  logic [NUM_SLOTS-1:0]        res_ready,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [1:0]                  m_node,
  output logic                        m_class,
  output logic signed [OUT_W-1:0]     m_score,
  output logic                        frame_done,
  output logic                        err_abort,
  output logic [FCNT_W-1:0]           frame_cnt
);
  state_t state, state_n;
  logic [NUM_SLOTS-1:0] got, got_n, cap_en;
  logic [1:0] node, node_n;
  logic [FCNT_W-1:0] cnt_n;
  logic done_n, abort_n, lost;
  logic signed [IN_W-1:0] cap [NUM_SLOTS];
  assign lost = |(got & ~res_ready);
  assign m_valid = state == SEND;
  assign m_node = node;
  always_comb begin
    state_n = state;
    got_n = got;
    node_n = node;
    cnt_n = frame_cnt;
    done_n = 1'b0;
    abort_n = 1'b0;
    cap_en = '0;
    case (state)
      ARM: begin
        got_n = '0;
        if (res_ready == '0) state_n = COLLECT;
      end
      COLLECT: begin
        if (lost) begin
          got_n = '0;
          abort_n = 1'b1;
          state_n = ARM;
        end else if (&got) begin
          state_n = SEND;
        end else begin
          cap_en = res_ready & ~got;
          got_n = got | cap_en;
        end
      end
      SEND: begin
        if (m_ready) begin
          node_n = node + 2'd1;
          if (node == 2'd3) begin
            done_n = 1'b1;
            cnt_n = frame_cnt + 1'b1;
            state_n = ARM;
          end
        end
      end
      default: state_n = ARM;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARM;
      got <= '0;
      node <= '0;
      frame_cnt <= '0;
      frame_done <= 1'b0;
      err_abort <= 1'b0;
    end else begin
      state <= state_n;
      got <= got_n;
      node <= node_n;
      frame_cnt <= cnt_n;
      frame_done <= done_n;
      err_abort <= abort_n;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_SLOTS; k++) cap[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_SLOTS; k++) if (cap_en[k]) cap[k] <= res_data[k*IN_W +: IN_W];
    end
  end
  gnn_sat_argmax #(.IN_W(IN_W), .OUT_W(OUT_W)) u_sat (
    .a(cap[slot(node, 1'b0)]),
    .b(cap[slot(node, 1'b1)]),
    .cls(m_class),
    .score(m_score)
  );
endmodule

// File: tb/tb_gnn_result_collector.sv
// tb_gnn_result_collector: scoreboard bench for gnn_result_collector with directed frames
module tb_gnn_result_collector;
  localparam int IN_W = 21;
  localparam int OUT_W = 16;
  localparam int FCNT_W = 8;
  typedef struct packed {
    logic [1:0] n;
    logic c;
    logic signed [15:0] s;
  } word_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [8*IN_W-1:0] res_data;
  logic [7:0] res_ready;
  logic m_valid, m_ready, m_class, frame_done, err_abort;
  logic [1:0] m_node;
  logic signed [OUT_W-1:0] m_score;
  logic [FCNT_W-1:0] frame_cnt;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  word_t exp_q[$];
  gnn_result_collector #(.IN_W(IN_W), .OUT_W(OUT_W), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .rst(rst), .res_data(res_data), .res_ready(res_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_node(m_node), .m_class(m_class),
    .m_score(m_score), .frame_done(frame_done), .err_abort(err_abort), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_node(input int n, input int a, input int b);
    res_data[2*n*IN_W +: IN_W] = IN_W'(a);
    res_data[(2*n+1)*IN_W +: IN_W] = IN_W'(b);
  endtask
  task automatic push(input int n, input int c, input int s);
    word_t w;
    w.n = 2'(n);
    w.c = 1'(c);
    w.s = 16'(s);
    exp_q.push_back(w);
  endtask
  task automatic drain(input int max);
    int i = 0;
    while (exp_q.size() > 0 && i < max) begin
      tick();
      i++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask
  task automatic basic_frame();
    set_node(0, 100, -5);
    set_node(1, -7, 12);
    set_node(2, 0, 0);
    set_node(3, -3, -2);
    push(0, 0, 100);
    push(1, 1, 12);
    push(2, 0, 0);
    push(3, 1, -2);
  endtask
  initial begin : monitor
    word_t held, e;
    logic stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (frame_done) done_cnt++;
        if (err_abort) abort_cnt++;
        if (stalled) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_word", {m_node, m_class, m_score}, held);
        end
        stalled = m_valid && !m_ready;
        held = {m_node, m_class, m_score};
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word node=%0d class=%0d score=%0d required=none", m_node, m_class, m_score);
          end else begin
            e = exp_q.pop_front();
            chk("word_node", m_node, e.n);
            chk("word_class", m_class, e.c);
            chk("word_score", m_score, e.s);
          end
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
  initial begin
    res_data = '0;
    res_ready = '0;
    m_ready = 1'b1;
    rst = 1'b1;
    tick(2);
    chk("rst_valid", m_valid, 0);
    chk("rst_node", m_node, 0);
    chk("rst_class", m_class, 0);
    chk("rst_score", m_score, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_abort", err_abort, 0);
    chk("rst_cnt", frame_cnt, 0);
    rst = 1'b0;
    tick(2);
    // basic frame, all slots in one cycle
    basic_frame();
    res_ready = 8'hFF;
    tick();
    chk("latency_lo", m_valid, 0);
    tick();
    chk("latency_hi", m_valid, 1);
    drain(20);
    chk("basic_cnt", frame_cnt, 1);
    chk("basic_done_pulse", frame_done, 1);
    // stale frame guard: ready stays high, nothing may be emitted
    tick(5);
    chk("stale_valid", m_valid, 0);
    chk("stale_done_cnt", done_cnt, 1);
    res_ready = '0;
    tick(2);
    // saturation
    set_node(0, 40000, -70000);
    set_node(1, -70000, -80000);
    set_node(2, 5, 6);
    set_node(3, -1, -1);
    push(0, 0, 32767);
    push(1, 0, -32768);
    push(2, 1, 6);
    push(3, 0, -1);
    res_ready = 8'hFF;
    drain(20);
    chk("sat_cnt", frame_cnt, 2);
    res_ready = '0;
    tick(2);
    // staggered ready 7..0 plus backpressure on node 1
    set_node(0, 1, 2);
    set_node(1, 300, -300);
    set_node(2, -1048576, 1048575);
    set_node(3, -50, -60);
    push(0, 1, 2);
    push(1, 0, 300);
    push(2, 1, 32767);
    push(3, 0, -50);
    for (int k = 7; k >= 0; k--) begin
      res_ready[k] = 1'b1;
      tick();
      chk("stagger_no_valid", m_valid, 0);
    end
    tick();
    chk("stagger_valid", m_valid, 1);
    tick();
    m_ready = 1'b0;
    chk("bp_node", m_node, 1);
    tick(3);
    chk("bp_hold_node", m_node, 1);
    chk("bp_hold_valid", m_valid, 1);
    m_ready = 1'b1;
    drain(20);
    chk("stagger_cnt", frame_cnt, 3);
    res_ready = '0;
    tick(2);
    // abort: slots 0-3 captured, then slot 2 ready drops
    basic_frame();
    exp_q.delete();
    res_ready = 8'h0F;
    tick();
    res_ready = 8'h7B;
    tick();
    chk("abort_pulse", err_abort, 1);
    tick();
    chk("abort_pulse_end", err_abort, 0);
    tick(3);
    chk("abort_no_valid", m_valid, 0);
    chk("abort_cnt_hold", frame_cnt, 3);
    chk("abort_count", abort_cnt, 1);
    res_ready = '0;
    tick(2);
    basic_frame();
    res_ready = 8'hFF;
    drain(20);
    chk("post_abort_cnt", frame_cnt, 4);
    res_ready = '0;
    tick(2);
    // async reset while node 2 is pending
    basic_frame();
    res_ready = 8'hFF;
    tick(4);
    m_ready = 1'b0;
    chk("pend_node", m_node, 2);
    chk("pend_valid", m_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", m_valid, 0);
    chk("arst_cnt", frame_cnt, 0);
    chk("arst_node", m_node, 0);
    exp_q.delete();
    tick(2);
    rst = 1'b0;
    m_ready = 1'b1;
    tick(3);
    chk("arst_rearm_valid", m_valid, 0);
    chk("arst_no_done", done_cnt, 4);
    res_ready = '0;
    tick(2);
    basic_frame();
    res_ready = 8'hFF;
    drain(20);
    chk("arst_restart_cnt", frame_cnt, 1);
    tick(2);
    chk("final_done_cnt", done_cnt, 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
